// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code to direction-control decoder: make/break prefix FSM, held-key
// tracking, per-axis last-pressed resolution. Define KEYDEC_WASD_EN to also map WASD.
module ps2_dir_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 100000,
  parameter logic [7:0]  START_CODE     = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] scan_code,
  output logic [3:0] dirMove,
  output logic [3:0] dir_pulse,
  output logic       start_pulse,
  output logic       any_held,
  output logic       proto_err
);

  localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_E0     = 2'd1,
    S_F0     = 2'd2,
    S_E0F0   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_timeout;

  logic              w_make;
  logic              w_brk;
  logic              w_ext;
  logic              w_err;

  logic [3:0]        r_arrow;
  logic [3:0]        w_arrow_hit;
  logic [3:0]        w_arrow_nxt;
  logic [3:0]        w_arrow_new;
  logic [3:0]        w_held_old;
  logic [3:0]        w_held_nxt;
  logic [3:0]        w_new;
  logic              r_ud;
  logic              r_lr;
  logic              w_ud_nxt;
  logic              w_lr_nxt;
  logic [3:0]        w_dir_res;
  logic              r_start_held;
  logic              w_start_hit;
  logic              w_start_nxt;
  logic              w_start_fire;

  logic [3:0]        r_dir;
  logic [3:0]        r_pulse;
  logic              r_start_pulse;
  logic              r_any;
  logic              r_err;

  assign w_timeout = (r_state != S_IDLE) && !code_valid && (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Prefix timeout counter: only runs while a sequence is open and the line is quiet
  always_ff @(posedge clk) begin
    if (reset || code_valid || (r_state == S_IDLE) || w_timeout) r_cnt <= '0;
    else                                                          r_cnt <= r_cnt + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (code_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (scan_code == CODE_F0)      w_state_nxt = S_F0;
          else if (scan_code == CODE_E0) w_state_nxt = S_E0;
        end
        S_E0: begin
          if (scan_code == CODE_F0)       w_state_nxt = S_E0F0;
          else if (scan_code != CODE_E0)  w_state_nxt = S_IDLE;
        end
        S_F0: begin
          if (scan_code == CODE_E0)       w_state_nxt = S_E0;
          else if (scan_code != CODE_F0)  w_state_nxt = S_IDLE;
        end
        S_E0F0:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Event decode: which key event (if any) the current byte completes
  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    w_err  = w_timeout;
    if (code_valid) begin
      unique case (r_state)
        S_IDLE: w_make = (scan_code != CODE_F0) && (scan_code != CODE_E0);
        S_E0: begin
          w_ext  = 1'b1;
          w_make = (scan_code != CODE_F0) && (scan_code != CODE_E0);
        end
        S_F0: begin
          w_brk = (scan_code != CODE_F0) && (scan_code != CODE_E0);
          w_err = (scan_code == CODE_E0);
        end
        S_E0F0: begin
          w_ext = 1'b1;
          w_brk = (scan_code != CODE_F0) && (scan_code != CODE_E0);
          w_err = (scan_code == CODE_F0) || (scan_code == CODE_E0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_arrow_hit = '0;
    if (w_ext) begin
      unique case (scan_code)
        CODE_UP:    w_arrow_hit = 4'b0001;
        CODE_DOWN:  w_arrow_hit = 4'b0010;
        CODE_LEFT:  w_arrow_hit = 4'b0100;
        CODE_RIGHT: w_arrow_hit = 4'b1000;
        default:    w_arrow_hit = '0;
      endcase
    end
  end

  assign w_arrow_nxt = w_make ? (r_arrow | w_arrow_hit) :
                       w_brk  ? (r_arrow & ~w_arrow_hit) : r_arrow;
  assign w_arrow_new = w_make ? (w_arrow_hit & ~r_arrow) : 4'b0000;

`ifdef KEYDEC_WASD_EN
  localparam logic [7:0] CODE_W = 8'h1D;
  localparam logic [7:0] CODE_S = 8'h1B;
  localparam logic [7:0] CODE_A = 8'h1C;
  localparam logic [7:0] CODE_D = 8'h23;

  logic [3:0] r_wasd;
  logic [3:0] w_wasd_hit;
  logic [3:0] w_wasd_nxt;
  logic [3:0] w_wasd_new;

  always_comb begin
    w_wasd_hit = '0;
    if (!w_ext) begin
      unique case (scan_code)
        CODE_W:  w_wasd_hit = 4'b0001;
        CODE_S:  w_wasd_hit = 4'b0010;
        CODE_A:  w_wasd_hit = 4'b0100;
        CODE_D:  w_wasd_hit = 4'b1000;
        default: w_wasd_hit = '0;
      endcase
    end
  end

  assign w_wasd_nxt = w_make ? (r_wasd | w_wasd_hit) :
                      w_brk  ? (r_wasd & ~w_wasd_hit) : r_wasd;
  assign w_wasd_new = w_make ? (w_wasd_hit & ~r_wasd) : 4'b0000;
  assign w_held_old = r_arrow | r_wasd;
  assign w_held_nxt = w_arrow_nxt | w_wasd_nxt;
  assign w_new      = w_arrow_new | w_wasd_new;

  always_ff @(posedge clk) begin
    if (reset) r_wasd <= '0;
    else       r_wasd <= w_wasd_nxt;
  end
`else
  assign w_held_old = r_arrow;
  assign w_held_nxt = w_arrow_nxt;
  assign w_new      = w_arrow_new;
`endif

  // Last-pressed per axis: 0 = up/left, 1 = down/right
  assign w_ud_nxt = w_new[0] ? 1'b0 : (w_new[1] ? 1'b1 : r_ud);
  assign w_lr_nxt = w_new[2] ? 1'b0 : (w_new[3] ? 1'b1 : r_lr);

  assign w_dir_res[0] = w_held_nxt[0] & (~w_held_nxt[1] | ~w_ud_nxt);
  assign w_dir_res[1] = w_held_nxt[1] & (~w_held_nxt[0] |  w_ud_nxt);
  assign w_dir_res[2] = w_held_nxt[2] & (~w_held_nxt[3] | ~w_lr_nxt);
  assign w_dir_res[3] = w_held_nxt[3] & (~w_held_nxt[2] |  w_lr_nxt);

  assign w_start_hit  = !w_ext && (scan_code == START_CODE);
  assign w_start_nxt  = (w_make && w_start_hit) ? 1'b1 :
                        (w_brk  && w_start_hit) ? 1'b0 : r_start_held;
  assign w_start_fire = w_make && w_start_hit && !r_start_held;

  // Held state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arrow       <= '0;
      r_ud          <= 1'b0;
      r_lr          <= 1'b0;
      r_start_held  <= 1'b0;
      r_dir         <= '0;
      r_pulse       <= '0;
      r_start_pulse <= 1'b0;
      r_any         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_arrow       <= w_arrow_nxt;
      r_ud          <= w_ud_nxt;
      r_lr          <= w_lr_nxt;
      r_start_held  <= w_start_nxt;
      r_dir         <= w_dir_res;
      r_pulse       <= w_held_nxt & ~w_held_old;
      r_start_pulse <= w_start_fire;
      r_any         <= |w_held_nxt;
      r_err         <= w_err;
    end
  end

  assign dirMove     = r_dir;
  assign dir_pulse   = r_pulse;
  assign start_pulse = r_start_pulse;
  assign any_held    = r_any;
  assign proto_err   = r_err;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Self-checking bench for ps2_dir_decoder: directed scenarios plus random byte
// streams, compared every cycle against a sequence-level reference model.
module tb_ps2_dir_decoder;

  localparam int P = 16;
  localparam logic [7:0] START = 8'h29;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [7:0] scan_code;
  logic [3:0] dirMove;
  logic [3:0] dir_pulse;
  logic       start_pulse;
  logic       any_held;
  logic       proto_err;

  int vectors;
  int miscompares;

  ps2_dir_decoder #(.PREFIX_TIMEOUT(P), .START_CODE(START)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .scan_code(scan_code),
    .dirMove(dirMove), .dir_pulse(dir_pulse), .start_pulse(start_pulse),
    .any_held(any_held), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending-prefix flags, held keys per source, last press per axis
  logic [3:0] m_arrow, m_wasd;
  logic       m_start;
  logic       m_ext, m_brk;
  logic [1:0] m_axis_last [2];
  int         m_now, m_last;
  logic [3:0] e_dir, e_pulse;
  logic       e_start, e_any, e_err;

  // Observation tallies for directed scenario checks
  int n_pulse0, n_pulse_any, n_start, n_err;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  task automatic key_event(input bit ext, input bit brk, input logic [7:0] c);
    bit         hit, wasd, was, own;
    logic [1:0] d;
    hit = 1'b0; wasd = 1'b0; d = 2'd0;
    if (ext) begin
      case (c)
        8'h75: begin hit = 1'b1; d = 2'd0; end
        8'h72: begin hit = 1'b1; d = 2'd1; end
        8'h6B: begin hit = 1'b1; d = 2'd2; end
        8'h74: begin hit = 1'b1; d = 2'd3; end
        default: ;
      endcase
    end else begin
`ifdef KEYDEC_WASD_EN
      case (c)
        8'h1D: begin hit = 1'b1; wasd = 1'b1; d = 2'd0; end
        8'h1B: begin hit = 1'b1; wasd = 1'b1; d = 2'd1; end
        8'h1C: begin hit = 1'b1; wasd = 1'b1; d = 2'd2; end
        8'h23: begin hit = 1'b1; wasd = 1'b1; d = 2'd3; end
        default: ;
      endcase
`endif
      if (c == START) begin
        if (brk) m_start = 1'b0;
        else if (!m_start) begin m_start = 1'b1; e_start = 1'b1; end
      end
    end
    if (hit) begin
      was = m_arrow[d] | m_wasd[d];
      own = wasd ? m_wasd[d] : m_arrow[d];
      if (brk) begin
        if (wasd) m_wasd[d] = 1'b0; else m_arrow[d] = 1'b0;
      end else if (!own) begin
        if (wasd) m_wasd[d] = 1'b1; else m_arrow[d] = 1'b1;
        if (!was) e_pulse[d] = 1'b1;
        m_axis_last[d[1]] = d;
      end
    end
  endtask

  function automatic logic [1:0] pick(input logic h_lo, input logic h_hi, input logic hi_last);
    if (h_lo && h_hi) return hi_last ? 2'b10 : 2'b01;
    return {h_hi, h_lo};
  endfunction

  task automatic model(input bit rst, input bit v, input logic [7:0] c);
    logic [3:0] held;
    e_pulse = '0; e_start = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_arrow = '0; m_wasd = '0; m_start = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
      m_axis_last[0] = 2'd0; m_axis_last[1] = 2'd2;
    end else if (v) begin
      m_last = m_now;
      if (!m_ext && !m_brk) begin
        if (c == 8'hF0) m_brk = 1'b1;
        else if (c == 8'hE0) m_ext = 1'b1;
        else key_event(1'b0, 1'b0, c);
      end else if (m_ext && !m_brk) begin
        if (c == 8'hF0) m_brk = 1'b1;
        else if (c != 8'hE0) begin key_event(1'b1, 1'b0, c); m_ext = 1'b0; end
      end else if (!m_ext && m_brk) begin
        if (c == 8'hE0) begin e_err = 1'b1; m_ext = 1'b1; m_brk = 1'b0; end
        else if (c != 8'hF0) begin key_event(1'b0, 1'b1, c); m_brk = 1'b0; end
      end else begin
        if (c == 8'hE0 || c == 8'hF0) e_err = 1'b1;
        else key_event(1'b1, 1'b1, c);
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if ((m_ext || m_brk) && (m_now - m_last == P)) begin
      m_ext = 1'b0; m_brk = 1'b0; e_err = 1'b1;
    end
    m_now++;
    held  = m_arrow | m_wasd;
    e_any = |held;
    e_dir = {pick(held[2], held[3], m_axis_last[1] == 2'd3),
             pick(held[0], held[1], m_axis_last[0] == 2'd1)};
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] c);
    reset = rst; code_valid = v; scan_code = c;
    @(posedge clk);
    model(rst, v, c);
    #1;
    chk("dirMove", dirMove, e_dir);
    chk("dir_pulse", dir_pulse, e_pulse);
    chk("start_pulse", {3'b000, start_pulse}, {3'b000, e_start});
    chk("any_held", {3'b000, any_held}, {3'b000, e_any});
    chk("proto_err", {3'b000, proto_err}, {3'b000, e_err});
    n_pulse0    += int'(dir_pulse[0]);
    n_pulse_any += int'(|dir_pulse);
    n_start     += int'(start_pulse);
    n_err       += int'(proto_err);
    reset = 1'b0; code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b0, 1'b1, c);
    idle(5);
  endtask

  task automatic clr_counts();
    n_pulse0 = 0; n_pulse_any = 0; n_start = 0; n_err = 0;
  endtask

  logic [7:0] pool [14];

  initial begin
    vectors = 0; miscompares = 0; m_now = 0; m_last = 0;
    reset = 1'b1; code_valid = 1'b0; scan_code = 8'h00;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29,
             8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'hF0, 8'h00};

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    chk("reset_dirMove", dirMove, 4'b0000);
    idle(2);

    // Up press
    clr_counts();
    send(8'hE0); send(8'h75);
    chk("up_dirMove", dirMove, 4'b0001);
    chk("up_any", {3'b000, any_held}, 4'b0001);
    chk("up_pulse_count", 4'(n_pulse0), 4'd1);

    // Typematic repeats, then release
    clr_counts();
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); end
    chk("typematic_pulses", 4'(n_pulse_any), 4'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("release_dirMove", dirMove, 4'b0000);
    chk("release_any", {3'b000, any_held}, 4'b0000);

    // Down then up: last pressed wins; release of winner exposes the other
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h75);
    chk("updown_dirMove", dirMove, 4'b0001);
    send(8'hE0); send(8'hF0);
    step(1'b0, 1'b1, 8'h75);
    chk("fallback_dirMove", dirMove, 4'b0010);
    idle(5);
    send(8'hE0); send(8'hF0); send(8'h72);

    // Prefix timeout, then the late byte is a plain base code
    clr_counts();
    step(1'b0, 1'b1, 8'hE0);
    idle(P + 4);
    chk("timeout_err_count", 4'(n_err), 4'd1);
    send(8'h75);
    chk("late_byte_dirMove", dirMove, 4'b0000);

    // Start key
    clr_counts();
    send(8'h29);
    chk("start_first", 4'(n_start), 4'd1);
    send(8'h29);
    chk("start_repeat", 4'(n_start), 4'd1);
    send(8'hF0); send(8'h29); send(8'h29);
    chk("start_again", 4'(n_start), 4'd2);
    send(8'hF0); send(8'h29);

    // Reset inside a sequence discards it
    send(8'hE0);
    step(1'b1, 1'b0, 8'h00);
    send(8'hF0); send(8'h75);
    chk("reset_mid_dirMove", dirMove, 4'b0000);

    // WASD up alongside arrow up
    clr_counts();
    send(8'h1D);
`ifdef KEYDEC_WASD_EN
    send(8'hE0); send(8'h75);
    chk("wasd_one_pulse", 4'(n_pulse0), 4'd1);
    send(8'hF0); send(8'h1D);
    chk("wasd_release_dir", dirMove, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
`else
    chk("wasd_ignored_dir", dirMove, 4'b0000);
`endif

    // Random byte streams with gaps, long silences and occasional resets
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) step(1'b1, 1'b0, 8'h00);
      else if (r < 6) idle(int'($urandom_range(P - 2, P + 3)));
      else if (r < 90) begin
        logic [7:0] c;
        c = pool[$urandom_range(0, 13)];
        if (c == 8'h00) c = 8'($urandom);
        step(1'b0, 1'b1, c);
      end else step(1'b0, 1'b0, 8'h00);
    end
    idle(P + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
